// File: rtl/pack_stream_pkg.sv
// Shared types for the pack bit serializer slice:
// FSM states, FIFO entry layout and the pack address helper.
package pack_stream_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SYNC,
        READ,
        DRAIN
    } state_t;

    typedef struct packed {
        logic data;
        logic sop;
        logic eop;
    } entry_t;

    typedef struct packed {
        logic sop;
        logic eop;
    } tag_t;

    function automatic int last_addr(input int size_bit_pack);
        return size_bit_pack - 1;
    endfunction

endpackage

// File: rtl/pack_skid_fifo.sv
// Register FIFO of serializer entries that absorbs sink backpressure.
// Push into a full FIFO is legal only when a pop happens in the same cycle.
module pack_skid_fifo
    import pack_stream_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic          push,
    input  entry_t        push_entry,
    input  logic          pop,
    output entry_t        head,
    output logic [CW-1:0] count,
    output logic          empty,
    output logic          full
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    entry_t        mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_entry;
                wr_ptr      <= nxt(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= nxt(rd_ptr);
            end
            unique case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    overflow_check : assert property (
        @(posedge i_clk) disable iff (i_reset) !(push && full && !do_pop)
    );

endmodule

// File: rtl/pack_bit_serializer.sv
// Pack memory reader: sweeps 0..LAST, absorbs read latency, emits a bit stream.
// Optional sync word prefix per pack when PACK_SYNC_WORD_EN is defined.
module pack_bit_serializer
    import pack_stream_pkg::*;
#(
    parameter int          SIZE_BIT_PACK = 1976,
    parameter int          SIZE_ADDR     = $clog2(SIZE_BIT_PACK),
    parameter int          READ_LATENCY  = 1,
    parameter int          FIFO_DEPTH    = 4,
    parameter int          SYNC_LEN      = 32,
    parameter logic [31:0] SYNC_WORD     = 32'h1ACFFC1D
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_run,
    output logic [SIZE_ADDR-1:0] o_addr,
    input  logic                 i_mem_data,
    output logic                 o_data,
    output logic                 o_valid,
    input  logic                 i_ready,
    output logic                 o_sop,
    output logic                 o_eop,
    output logic                 o_pack_done,
    output logic                 o_busy
);

    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int OW = $clog2(FIFO_DEPTH + READ_LATENCY + 1);
    localparam logic [SIZE_ADDR-1:0] LAST    = SIZE_ADDR'(last_addr(SIZE_BIT_PACK));
    localparam logic [SIZE_ADDR-1:0] LAST_M1 = SIZE_ADDR'(last_addr(SIZE_BIT_PACK) - 1);
    localparam logic [OW-1:0]        DEPTH_O = OW'(FIFO_DEPTH);
    localparam logic [OW-1:0]        DEPTH_2 = OW'(FIFO_DEPTH - 2);

    state_t                  state;
    state_t                  state_nx;
    logic                    issue;
    logic                    sync_push;
    logic                    sync_done;
    logic                    sync_bit;
    logic                    sync_first;
    logic                    push;
    entry_t                  push_entry;
    entry_t                  head;
    logic [CW-1:0]           fifo_count;
    logic                    fifo_empty;
    logic                    fifo_full;
    logic [READ_LATENCY-1:0] sr_vld;
    tag_t [READ_LATENCY-1:0] sr_tag;
    logic [OW-1:0]           inflight;
    logic [OW-1:0]           occ;
    logic                    last_issue;
    logic                    drained;

`ifdef PACK_SYNC_WORD_EN
    localparam bit     SYNC_EN = 1'b1;
    localparam state_t FIRST   = SYNC;
    localparam int     SC      = $clog2(SYNC_LEN);

    logic [SC-1:0] sync_cnt;

    assign sync_done  = sync_push && (sync_cnt == SC'(SYNC_LEN - 1));
    assign sync_bit   = SYNC_WORD[SC'(SYNC_LEN - 1) - sync_cnt];
    assign sync_first = (sync_cnt == '0);

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            sync_cnt <= '0;
        end else if (sync_push) begin
            sync_cnt <= sync_done ? '0 : sync_cnt + 1'b1;
        end
    end
`else
    localparam bit     SYNC_EN = 1'b0;
    localparam state_t FIRST   = READ;

    logic unused_sync;

    assign unused_sync = ^{SYNC_WORD, SYNC_LEN};
    assign sync_done   = 1'b0;
    assign sync_bit    = 1'b0;
    assign sync_first  = 1'b0;
`endif

    always_comb begin
        inflight = '0;
        for (int i = 0; i < READ_LATENCY; i++) begin
            inflight = inflight + OW'(sr_vld[i]);
        end
    end

    assign occ        = OW'(fifo_count) + inflight;
    assign drained    = fifo_empty && (inflight == '0);
    assign last_issue = issue && (o_addr == LAST);

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (i_run) state_nx = FIRST;
            SYNC:    if (sync_done) state_nx = READ;
            READ:    if (last_issue) state_nx = i_run ? FIRST : DRAIN;
            DRAIN:   if (drained) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Holding back LAST-1 until two slots are free keeps LAST on o_addr for one cycle only.
    always_comb begin
        issue     = 1'b0;
        sync_push = 1'b0;
        unique case (state)
            READ: issue = (occ < DEPTH_O) &&
                          ((o_addr != LAST_M1) || (occ <= DEPTH_2));
            SYNC: sync_push = SYNC_EN && (inflight == '0) && !fifo_full;
            default: ;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            o_addr <= '0;
        end else if (issue) begin
            o_addr <= (o_addr == LAST) ? '0 : o_addr + 1'b1;
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            sr_vld <= '0;
            sr_tag <= '0;
        end else begin
            sr_vld[0] <= issue;
            sr_tag[0] <= '{sop: (o_addr == '0) && !SYNC_EN, eop: (o_addr == LAST)};
            for (int i = 1; i < READ_LATENCY; i++) begin
                sr_vld[i] <= sr_vld[i-1];
                sr_tag[i] <= sr_tag[i-1];
            end
        end
    end

    always_comb begin
        push = sr_vld[READ_LATENCY-1] || sync_push;
        if (sync_push) begin
            push_entry = '{data: sync_bit, sop: sync_first, eop: 1'b0};
        end else begin
            push_entry = '{data: i_mem_data,
                           sop:  sr_tag[READ_LATENCY-1].sop,
                           eop:  sr_tag[READ_LATENCY-1].eop};
        end
    end

    pack_skid_fifo #(
        .DEPTH (FIFO_DEPTH),
        .CW    (CW)
    ) u_fifo (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .push       (push),
        .push_entry (push_entry),
        .pop        (o_valid && i_ready),
        .head       (head),
        .count      (fifo_count),
        .empty      (fifo_empty),
        .full       (fifo_full)
    );

    assign o_valid     = !fifo_empty;
    assign o_data      = head.data && o_valid;
    assign o_sop       = head.sop && o_valid;
    assign o_eop       = head.eop && o_valid;
    assign o_pack_done = last_issue;
    assign o_busy      = (state != IDLE) || !drained;

endmodule

// File: tb/tb_pack_bit_serializer.sv
// Bench for pack_bit_serializer: scenario table, stall and reset sequences,
// every emitted bit compared against a scoreboard queue.
`timescale 1ns/1ps
module tb_pack_bit_serializer;

    localparam int LEN  = 1976;
    localparam int LAST = LEN - 1;
`ifdef PACK_SYNC_WORD_EN
    localparam int PRE = 32;
    localparam int LAT = 2;
`else
    localparam int PRE = 0;
    localparam int LAT = 3;
`endif
    localparam int PL = LEN + PRE;
    localparam logic [31:0] SYNC_WORD = 32'h1ACFFC1D;

    logic        i_clk;
    logic        i_reset;
    logic        i_run;
    logic        i_mem_data;
    logic        i_ready;
    logic [10:0] o_addr;
    logic        o_data;
    logic        o_valid;
    logic        o_sop;
    logic        o_eop;
    logic        o_pack_done;
    logic        o_busy;

    pack_bit_serializer dut (
        .i_clk       (i_clk),
        .i_reset     (i_reset),
        .i_run       (i_run),
        .o_addr      (o_addr),
        .i_mem_data  (i_mem_data),
        .o_data      (o_data),
        .o_valid     (o_valid),
        .i_ready     (i_ready),
        .o_sop       (o_sop),
        .o_eop       (o_eop),
        .o_pack_done (o_pack_done),
        .o_busy      (o_busy)
    );

    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    int checks = 0;
    int passed = 0;

    task automatic check(input string nm, input int act, input int exp);
        checks++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    // pack memory model, one cycle read latency
    int   mode = 0;
    logic mem_q = 1'b0;

    function automatic logic pat(input int m, input logic [10:0] a);
        return (m == 0) ? a[0] : ^(a & 11'h4B3);
    endfunction

    always @(posedge i_clk) mem_q <= pat(mode, o_addr);
    assign i_mem_data = mem_q;

    int ready_pct = 100;

    initial begin
        i_ready = 1'b0;
        forever begin
            @(posedge i_clk);
            #2;
            i_ready = ($urandom_range(0, 99) < ready_pct);
        end
    end

    logic [2:0] sb[$];
    int   rx_count = 0;
    int   done_cnt = 0;
    int   last_run_err = 0;
    int   stable_err = 0;
    int   cyc = 0;
    int   first_x = 0;
    int   last_x = 0;
    logic prev_last = 1'b0;
    logic prev_stall = 1'b0;
    logic [2:0] prev_out = '0;

    always @(negedge i_clk) begin
        cyc++;
        if (i_reset) begin
            prev_last  = 1'b0;
            prev_stall = 1'b0;
        end else begin
            if (o_pack_done) done_cnt++;
            if (o_addr == 11'(LAST) && prev_last) last_run_err++;
            prev_last = (o_addr == 11'(LAST));
            if (prev_stall && ({o_data, o_sop, o_eop} != prev_out)) stable_err++;
            prev_stall = o_valid && !i_ready;
            prev_out   = {o_data, o_sop, o_eop};
            if (o_valid && i_ready) begin
                if (sb.size() == 0) check("sb_underflow", 1, 0);
                else check("stream_bit", int'({o_data, o_sop, o_eop}), int'(sb.pop_front()));
                if (rx_count == 0) first_x = cyc;
                last_x = cyc;
                rx_count++;
            end
        end
    end

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic start_scn(input int m);
        mode = m;
        rx_count = 0;
        done_cnt = 0;
        last_run_err = 0;
        stable_err = 0;
    endtask

    task automatic push_pack(input int m);
        for (int i = 0; i < PRE; i++) sb.push_back({SYNC_WORD[31-i], i == 0, 1'b0});
        for (int a = 0; a < LEN; a++) sb.push_back({pat(m, 11'(a)), PRE == 0 && a == 0, a == LAST});
    endtask

    task automatic run_until_rx(input int target, input int budget);
        int n = 0;
        while (rx_count < target && n < budget) begin
            tick();
            n++;
        end
        check("rx_progress", int'(rx_count >= target), 1);
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (o_busy && n < budget) begin
            tick();
            n++;
        end
        check("drain_to_idle", int'(o_busy), 0);
    endtask

    typedef struct {
        string name;
        int    mode;
        int    pct;
        int    packs;
        int    drop;
        int    exp_bits;
        int    exp_done;
    } vec_t;

    initial begin
        vec_t tbl[4];
        int   n;
        int   n_stop;
        tbl[0] = '{"full_rate",  0, 100, 2, 10,   2*PL, 2};
        tbl[1] = '{"rand_ready", 1, 50,  3, 700,  3*PL, 3};
        tbl[2] = '{"run_drop",   1, 100, 1, 100,  PL,   1};
        tbl[3] = '{"slow_ready", 0, 25,  1, 1500, PL,   1};

        i_reset = 1'b1;
        i_run   = 1'b0;
        repeat (3) @(posedge i_clk);
        @(negedge i_clk);
        check("rst_addr", int'(o_addr), 0);
        check("rst_valid", int'(o_valid), 0);
        check("rst_data", int'(o_data), 0);
        check("rst_sop", int'(o_sop), 0);
        check("rst_eop", int'(o_eop), 0);
        check("rst_done", int'(o_pack_done), 0);
        check("rst_busy", int'(o_busy), 0);
        tick();
        i_reset = 1'b0;
        tick();

        foreach (tbl[k]) begin
            start_scn(tbl[k].mode);
            for (int p = 0; p < tbl[k].packs; p++) push_pack(tbl[k].mode);
            ready_pct = tbl[k].pct;
            tick();
            i_run = 1'b1;
            run_until_rx((tbl[k].packs - 1) * PL + tbl[k].drop,
                         tbl[k].packs * PL * 150 / tbl[k].pct + 200);
            i_run = 1'b0;
            wait_idle(PL * 150 / tbl[k].pct + 200);
            check({tbl[k].name, "_bits"}, rx_count, tbl[k].exp_bits);
            check({tbl[k].name, "_pack_done"}, done_cnt, tbl[k].exp_done);
            check({tbl[k].name, "_sb_left"}, sb.size(), 0);
            check({tbl[k].name, "_addr_last_twice"}, last_run_err, 0);
            check({tbl[k].name, "_held_stable"}, stable_err, 0);
            check({tbl[k].name, "_valid_idle"}, int'(o_valid), 0);
`ifndef PACK_SYNC_WORD_EN
            if (tbl[k].pct == 100)
                check({tbl[k].name, "_gapless"}, last_x - first_x + 1, tbl[k].exp_bits);
`endif
            sb.delete();
        end

        // stall mid-pack with the sink closed for 20 cycles
        start_scn(1);
        push_pack(1);
        ready_pct = 100;
        tick();
        i_run = 1'b1;
        n = 0;
        while (n < 10) begin
            @(posedge i_clk);
            n++;
            #1;
            if (o_valid) break;
        end
        check("first_latency", n, LAT);
        run_until_rx(300, 2000);
        n_stop = rx_count;
        ready_pct = 0;
        repeat (20) tick();
        check("stall_addr", int'(o_addr), n_stop - PRE + 4);
        check("stall_valid", int'(o_valid), 1);
        check("stall_rx", rx_count, n_stop);
        check("stall_head", int'({o_data, o_sop, o_eop}), int'(sb[0]));
        ready_pct = 100;
        i_run = 1'b0;
        wait_idle(PL * 2);
        check("stall_bits", rx_count, PL);
        check("stall_pack_done", done_cnt, 1);
        check("stall_held_stable", stable_err, 0);
        check("stall_sb_left", sb.size(), 0);
        sb.delete();

        // reset in the middle of a pack
        start_scn(0);
        push_pack(0);
        tick();
        i_run = 1'b1;
        n = 0;
        while (o_addr != 11'd500 && n < 3000) begin
            tick();
            n++;
        end
        check("reach_addr500", int'(o_addr), 500);
        i_reset = 1'b1;
        i_run   = 1'b0;
        @(negedge i_clk);
        check("midrst_addr", int'(o_addr), 0);
        check("midrst_valid", int'(o_valid), 0);
        check("midrst_data", int'(o_data), 0);
        check("midrst_sop", int'(o_sop), 0);
        check("midrst_eop", int'(o_eop), 0);
        check("midrst_done", int'(o_pack_done), 0);
        check("midrst_busy", int'(o_busy), 0);
        sb.delete();
        tick();
        i_reset = 1'b0;
        start_scn(0);
        push_pack(0);
        tick();
        i_run = 1'b1;
        run_until_rx(50, 1000);
        i_run = 1'b0;
        wait_idle(PL * 2);
        check("post_rst_bits", rx_count, PL);
        check("post_rst_pack_done", done_cnt, 1);
        check("post_rst_sb_left", sb.size(), 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d so far", passed, checks);
        $fatal(1, "watchdog");
    end

endmodule
